// File: rtl/xor_stream_decrypter.sv
// ============================================================================
//  Module   : xor_stream_decrypter
//  Purpose  : Framed XOR stream decrypter with rotated key and registered
//             valid/ready output. Optional build macro: XOR_ROLLING_KEY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_stream_decrypter (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  key,
   input  logic [2:0]  shift,
   input  logic        start,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   input  logic        m_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] byte_count
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_load  = 2'd1;
   localparam logic [1:0] c_st_run   = 2'd2;
   localparam logic [1:0] c_st_drain = 2'd3;

   logic [1:0]  r_state;
   logic [7:0]  r_key;
   logic [2:0]  r_shift;
   logic [7:0]  r_cur_key;
   logic        r_m_valid;
   logic [7:0]  r_m_data;
   logic        r_m_last;
   logic        r_done;
   logic [15:0] r_byte_count;

   logic        w_s_ready;
   logic        w_accept;
   logic        w_out_hs;
   logic [7:0]  w_rot_key;
   logic [15:0] w_rot_wide;

   // Rotating a doubled copy keeps the wrap-around bits without an 8-shift term.
   assign w_rot_wide = {r_key, r_key} << r_shift;
   assign w_rot_key  = w_rot_wide[15:8];

   assign w_s_ready = (r_state == c_st_run) && (!r_m_valid || m_ready);
   assign w_accept  = s_valid && w_s_ready;
   assign w_out_hs  = r_m_valid && m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_st_idle;
         r_key        <= 8'h00;
         r_shift      <= 3'd0;
         r_cur_key    <= 8'h00;
         r_m_valid    <= 1'b0;
         r_m_data     <= 8'h00;
         r_m_last     <= 1'b0;
         r_done       <= 1'b0;
         r_byte_count <= 16'h0000;
      end else begin
         r_done <= 1'b0;

         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_key        <= key;
                  r_shift      <= shift;
                  r_byte_count <= 16'h0000;
                  r_state      <= c_st_load;
               end
            end
            c_st_load: begin
               r_cur_key <= w_rot_key;
               r_state   <= c_st_run;
            end
            c_st_run: begin
               if (w_accept && s_last) begin
                  r_state <= c_st_drain;
               end
            end
            c_st_drain: begin
               if (w_out_hs && r_m_last) begin
                  r_done  <= 1'b1;
                  r_state <= c_st_idle;
               end
            end
            default: r_state <= c_st_idle;
         endcase

         // A new byte takes priority so the register reloads without a bubble.
         if (w_accept) begin
            r_m_data  <= s_data ^ r_cur_key;
            r_m_last  <= s_last;
            r_m_valid <= 1'b1;
            if (r_byte_count != 16'hFFFF) begin
               r_byte_count <= r_byte_count + 16'd1;
            end
`ifdef XOR_ROLLING_KEY_EN
            r_cur_key <= {r_cur_key[6:0], r_cur_key[7]};
`endif
         end else if (w_out_hs) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign s_ready    = w_s_ready;
   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_last     = r_m_last;
   assign busy       = (r_state != c_st_idle);
   assign done       = r_done;
   assign byte_count = r_byte_count;

endmodule

`default_nettype wire
